// File: rtl/ysyx_24100027_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// request/response port and hands {inst, pc, fault} to decode with valid/ready.
module ysyx_24100027_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt
);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        DRAIN,
        HOLD,
        HALT
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        halt_pend, halt_pend_n;
    logic        redir_pend, redir_pend_n;
    logic [31:0] redir_target, redir_target_n;
    logic        out_valid_n;
    logic [31:0] out_inst_n;
    logic [31:0] out_pc_n;
    logic        out_fault_n;

    logic        halt_now;
    logic        go_req;
    logic [31:0] req_target;

    assign halt_now       = halt_pend | halt;
    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_n        = state;
        pc_n           = pc;
        halt_pend_n    = halt_now;
        redir_pend_n   = redir_pend;
        redir_target_n = redir_target;
        out_valid_n    = out_valid;
        out_inst_n     = out_inst;
        out_pc_n       = out_pc;
        out_fault_n    = out_fault;
        go_req         = 1'b0;
        req_target     = pc;

        unique case (state)
            BOOT: begin
                go_req     = 1'b1;
                req_target = pc;
            end
            REQ: begin
                if (imem_req_ready) begin
                    if (redirect_valid || redir_pend) begin
                        // The issued fetch still completes; its response is dropped in DRAIN.
                        state_n      = DRAIN;
                        pc_n         = redirect_valid ? redirect_pc : redir_target;
                        redir_pend_n = 1'b0;
                    end else begin
                        state_n = WAIT;
                    end
                end else if (redirect_valid) begin
                    redir_pend_n   = 1'b1;
                    redir_target_n = redirect_pc;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                    if (imem_rsp_valid) begin
                        go_req     = 1'b1;
                        req_target = redirect_pc;
                    end else begin
                        state_n = DRAIN;
                    end
                end else if (imem_rsp_valid) begin
                    out_valid_n = 1'b1;
                    out_inst_n  = imem_rsp_err ? NOP_INST : imem_rsp_data;
                    out_fault_n = imem_rsp_err;
                    out_pc_n    = pc;
                    state_n     = HOLD;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                end
                if (imem_rsp_valid) begin
                    go_req     = 1'b1;
                    req_target = redirect_valid ? redirect_pc : pc;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    out_valid_n = 1'b0;
                    go_req      = 1'b1;
                    req_target  = redirect_pc;
                end else if (out_ready) begin
                    out_valid_n = 1'b0;
                    go_req      = 1'b1;
                    req_target  = pc + 32'd4;
                end
            end
            HALT: begin
                out_valid_n = 1'b0;
            end
            default: begin
                state_n = BOOT;
            end
        endcase

        // Common exit toward REQ: halt takes precedence, then misaligned-target faulting.
        if (go_req) begin
            pc_n = req_target;
            if (halt_now) begin
                state_n     = HALT;
                out_valid_n = 1'b0;
            end else if (req_target[1:0] != 2'b00) begin
                state_n     = HOLD;
                out_valid_n = 1'b1;
                out_inst_n  = NOP_INST;
                out_fault_n = 1'b1;
                out_pc_n    = req_target;
            end else begin
                state_n = REQ;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            halt_pend    <= 1'b0;
            redir_pend   <= 1'b0;
            redir_target <= '0;
            out_valid    <= 1'b0;
            out_inst     <= NOP_INST;
            out_pc       <= RESET_PC;
            out_fault    <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            halt_pend    <= halt_pend_n;
            redir_pend   <= redir_pend_n;
            redir_target <= redir_target_n;
            out_valid    <= out_valid_n;
            out_inst     <= out_inst_n;
            out_pc       <= out_pc_n;
            out_fault    <= out_fault_n;
        end
    end

endmodule

// File: tb/tb_ysyx_24100027_ifu.sv
// Directed bench for the fetch unit: an imem model with programmable latency,
// scoreboard queues for expected requests and expected decode handshakes.
module tb_ysyx_24100027_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } out_t;

    logic [31:0] exp_req[$];
    out_t        exp_out[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          mem_lat = 1;
    logic [31:0] err_addr = 32'hFFFF_FFF0;

    ysyx_24100027_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_fault      (out_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return addr ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_out(input logic [31:0] pc, input logic [31:0] inst, input logic fault);
        out_t e;
        e.pc    = pc;
        e.inst  = inst;
        e.fault = fault;
        exp_out.push_back(e);
    endtask

    // Waits until the decode side shows out_valid with the given pc.
    task automatic wait_out(input logic [31:0] pc, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (out_valid && out_pc == pc) seen = 1'b1;
            else step(1);
        end
        n_cmp++;
        assert (seen)
        else begin
            n_err++;
            $error("FAIL wait_out observed=timeout expected pc=%h", pc);
        end
    endtask

    // Instruction memory model plus request-address scoreboard.
    initial begin
        bit          fire;
        logic [31:0] addr;
        logic [31:0] pend;
        int          cnt;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        pend           = '0;
        cnt            = 0;
        forever begin
            @(negedge clk);
            fire = !rst && imem_req_valid && imem_req_ready;
            addr = imem_req_addr;
            if (fire) begin
                n_cmp++;
                assert (exp_req.size() > 0)
                else begin
                    n_err++;
                    $error("FAIL req_unexpected observed addr=%h expected none", addr);
                end
                if (exp_req.size() > 0) check("req_addr", addr, exp_req.pop_front());
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
            if (rst) begin
                cnt = 0;
            end else begin
                if (fire) begin
                    cnt  = mem_lat;
                    pend = addr;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_err   = (pend == err_addr);
                        imem_rsp_data  = (pend == err_addr) ? 32'hDEAD_BEEF : inst_of(pend);
                    end
                end
            end
        end
    end

    // Decode-side handshake scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            assert (exp_out.size() > 0)
            else begin
                n_err++;
                $error("FAIL out_unexpected observed pc=%h expected none", out_pc);
            end
            if (exp_out.size() > 0) begin
                out_t e;
                e = exp_out.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_inst", out_inst, e.inst);
                check("out_fault", {31'd0, out_fault}, {31'd0, e.fault});
            end
        end
    end

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        step(2);

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_inst", out_inst, NOP_INST);
        check("rst_out_pc", out_pc, RESET_PC);
        check("rst_out_fault", {31'd0, out_fault}, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

        // Sequential fetch, latency 1, decode always ready
        for (int i = 0; i < 4; i++) exp_req.push_back(RESET_PC + 32'(4 * i));
        for (int i = 0; i < 3; i++) push_out(RESET_PC + 32'(4 * i), inst_of(RESET_PC + 32'(4 * i)), 1'b0);
        out_ready = 1'b1;
        rst = 1'b0;
        check("boot_req_valid", {31'd0, imem_req_valid}, 32'd0);
        step(1);
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, RESET_PC);
        wait_out(32'h8000_000C, 40);
        out_ready = 1'b0;

        // Stall in HOLD: outputs stable, no new request
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_pc", out_pc, 32'h8000_000C);
            check("hold_inst", out_inst, inst_of(32'h8000_000C));
            check("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        push_out(32'h8000_000C, inst_of(32'h8000_000C), 1'b0);
        exp_req.push_back(32'h8000_0010);
        out_ready = 1'b1;
        wait_out(32'h8000_0010, 20);
        out_ready = 1'b0;

        // Redirect in HOLD together with out_ready: target wins over pc+4
        push_out(32'h8000_0010, inst_of(32'h8000_0010), 1'b0);
        exp_req.push_back(32'h8000_0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        out_ready      = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        check("redir_hold_req_addr", imem_req_addr, 32'h8000_0100);
        wait_out(32'h8000_0100, 20);

        // Redirect in WAIT with a slow response: that response is dropped
        mem_lat = 3;
        push_out(32'h8000_0100, inst_of(32'h8000_0100), 1'b0);
        exp_req.push_back(32'h8000_0104);
        exp_req.push_back(32'h8000_0200);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step(1);
        redirect_valid = 1'b0;
        check("drain_no_req", {31'd0, imem_req_valid}, 32'd0);
        check("drain_no_out", {31'd0, out_valid}, 32'd0);
        wait_out(32'h8000_0200, 30);
        check("redir_wait_inst", out_inst, inst_of(32'h8000_0200));

        // Redirect while the request is stalled: address held until accept
        mem_lat        = 1;
        imem_req_ready = 1'b0;
        push_out(32'h8000_0200, inst_of(32'h8000_0200), 1'b0);
        exp_req.push_back(32'h8000_0204);
        exp_req.push_back(32'h8000_0300);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("stall_req_addr0", imem_req_addr, 32'h8000_0204);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        step(1);
        redirect_valid = 1'b0;
        check("stall_req_addr1", imem_req_addr, 32'h8000_0204);
        step(1);
        check("stall_req_addr2", imem_req_addr, 32'h8000_0204);
        imem_req_ready = 1'b1;
        step(1);
        check("stall_drain_no_req", {31'd0, imem_req_valid}, 32'd0);
        wait_out(32'h8000_0300, 20);

        // Access fault, then a misaligned redirect that faults without a request
        err_addr = 32'h8000_0304;
        push_out(32'h8000_0300, inst_of(32'h8000_0300), 1'b0);
        exp_req.push_back(32'h8000_0304);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        wait_out(32'h8000_0304, 20);
        check("err_inst", out_inst, NOP_INST);
        check("err_fault", {31'd0, out_fault}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        step(1);
        redirect_valid = 1'b0;
        check("mis_valid", {31'd0, out_valid}, 32'd1);
        check("mis_pc", out_pc, 32'h8000_0102);
        check("mis_inst", out_inst, NOP_INST);
        check("mis_fault", {31'd0, out_fault}, 32'd1);
        check("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
        step(1);
        check("mis_still_no_req", {31'd0, imem_req_valid}, 32'd0);
        exp_req.push_back(32'h8000_0400);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        step(1);
        redirect_valid = 1'b0;
        check("realign_out_valid", {31'd0, out_valid}, 32'd0);
        wait_out(32'h8000_0400, 20);

        // Halt during WAIT: in-flight instruction still delivered, then nothing
        mem_lat = 3;
        push_out(32'h8000_0400, inst_of(32'h8000_0400), 1'b0);
        push_out(32'h8000_0404, inst_of(32'h8000_0404), 1'b0);
        exp_req.push_back(32'h8000_0404);
        out_ready = 1'b1;
        step(2);
        halt = 1'b1;
        step(1);
        halt = 1'b0;
        wait_out(32'h8000_0404, 20);
        step(1);
        for (int i = 0; i < 8; i++) begin
            check("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
            check("halt_no_out", {31'd0, out_valid}, 32'd0);
            step(1);
        end

        // Reset restarts fetch at RESET_PC
        out_ready = 1'b0;
        mem_lat   = 1;
        rst       = 1'b1;
        #1;
        check("rst2_out_pc", out_pc, RESET_PC);
        check("rst2_req_valid", {31'd0, imem_req_valid}, 32'd0);
        step(2);
        exp_req.push_back(RESET_PC);
        rst = 1'b0;
        check("rst2_boot_req", {31'd0, imem_req_valid}, 32'd0);
        step(1);
        check("rst2_req_addr", imem_req_addr, RESET_PC);
        wait_out(RESET_PC, 20);
        check("rst2_inst", out_inst, inst_of(RESET_PC));
        step(2);

        check("req_queue_empty", 32'(exp_req.size()), 32'd0);
        check("out_queue_empty", 32'(exp_out.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
